// File: rtl/lane_pkg.sv
// Shared types for the single-lane driveway arbiter.
// Build option: LANE_STATS_EN (see lane_arbiter.sv).
package lane_pkg;

    typedef enum logic [1:0] {IDLE, GRANT_IN, GRANT_OUT, GUARD} lane_state_t;
    typedef enum logic {DIR_IN, DIR_OUT} lane_dir_t;

    // The shared timer must be able to hold both the grant and the guard limits.
    function automatic int lane_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lane_arbiter_if.sv
// Sensor, gate-light and status signals of the lane arbiter.
// Build option: LANE_STATS_EN adds the per-direction passage counters.
interface lane_arbiter_if;
    logic       in_req;
    logic       out_req;
    logic       enter;
    logic       exit;
    logic       full;
    logic       clear;
    logic       in_grant;
    logic       out_grant;
    logic       busy;
    logic       timeout;
    logic       wrong_dir;
`ifdef LANE_STATS_EN
    logic [7:0] in_served;
    logic [7:0] out_served;

    modport master (
        output in_req, out_req, enter, exit, full, clear,
        input  in_grant, out_grant, busy, timeout, wrong_dir, in_served, out_served
    );
    modport slave (
        input  in_req, out_req, enter, exit, full, clear,
        output in_grant, out_grant, busy, timeout, wrong_dir, in_served, out_served
    );
`else
    modport master (
        output in_req, out_req, enter, exit, full, clear,
        input  in_grant, out_grant, busy, timeout, wrong_dir
    );
    modport slave (
        input  in_req, out_req, enter, exit, full, clear,
        output in_grant, out_grant, busy, timeout, wrong_dir
    );
`endif
endinterface

// File: rtl/lane_timer.sv
// Saturating up-counter with synchronous clear and terminal-count compare.
module lane_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] tc_val,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // Count while enabled; hold at all-ones so the value never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == tc_val);

endmodule

// File: rtl/lane_arbiter.sv
// Grants the shared driveway lane to entry or exit traffic, one direction
// at a time, with passage/timeout release and a guard gap between grants.
// Build option: LANE_STATS_EN adds saturating in_served/out_served counters.
//
// state     | meaning
// IDLE      | no grant, waiting for an eligible request
// GRANT_IN  | entry light green, waiting for enter pulse or timeout
// GRANT_OUT | exit light green, waiting for exit pulse or timeout
// GUARD     | both lights red for GUARD cycles before re-arbitrating
module lane_arbiter
    import lane_pkg::*;
#(
    parameter int TIMEOUT = 50,
    parameter int GUARD   = 2
) (
    input  logic           clk,
    input  logic           reset,
    lane_arbiter_if.slave  bus
);

    localparam lane_state_t S_IDLE      = lane_pkg::IDLE;
    localparam lane_state_t S_GRANT_IN  = lane_pkg::GRANT_IN;
    localparam lane_state_t S_GRANT_OUT = lane_pkg::GRANT_OUT;
    localparam lane_state_t S_GUARD     = lane_pkg::GUARD;

    localparam int             TW    = $clog2(lane_max(TIMEOUT, GUARD) + 1);
    localparam logic [TW-1:0]  TO_TC = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  GD_TC = TW'(GUARD - 1);

    lane_state_t   state;
    lane_state_t   next_state;
    lane_state_t   pick;
    lane_dir_t     last_served;
    logic          in_elig;
    logic          out_elig;
    logic          match;
    logic          expire;
    logic          opposite;
    logic          t_clr;
    logic          t_en;
    logic          t_tc;
    logic [TW-1:0] t_tc_val;

    assign in_elig  = bus.in_req  & ~bus.full;
    assign out_elig = bus.out_req & ~bus.clear;

    // Round-robin choice among eligible directions; ties go against last_served.
    always_comb begin
        pick = S_IDLE;
        if (in_elig && out_elig) begin
            pick = (last_served == DIR_OUT) ? S_GRANT_IN : S_GRANT_OUT;
        end else if (in_elig) begin
            pick = S_GRANT_IN;
        end else if (out_elig) begin
            pick = S_GRANT_OUT;
        end
    end

    // Release conditions during a grant; a passage pulse beats an expiring timer.
    always_comb begin
        match    = 1'b0;
        opposite = 1'b0;
        if (state == S_GRANT_IN) begin
            match    = bus.enter;
            opposite = bus.exit;
        end else if (state == S_GRANT_OUT) begin
            match    = bus.exit;
            opposite = bus.enter;
        end
        expire = ((state == S_GRANT_IN) || (state == S_GRANT_OUT)) && t_tc && !match;
    end

    // Next-state decode; the guard exit arbitrates directly so back-to-back
    // grants are separated by exactly GUARD dark cycles.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      next_state = pick;
            S_GRANT_IN,
            S_GRANT_OUT: if (match || t_tc) next_state = S_GUARD;
            S_GUARD:     if (t_tc) next_state = pick;
            default:     next_state = S_IDLE;
        endcase
    end

    assign t_clr    = (next_state != state);
    assign t_en     = (state != S_IDLE);
    assign t_tc_val = (state == S_GUARD) ? GD_TC : TO_TC;

    lane_timer #(.WIDTH(TW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (t_clr),
        .en     (t_en),
        .tc_val (t_tc_val),
        .tc     (t_tc)
    );

    // State, fairness pointer and registered outputs decoded from next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            last_served   <= DIR_OUT;
            bus.in_grant  <= 1'b0;
            bus.out_grant <= 1'b0;
            bus.busy      <= 1'b0;
            bus.timeout   <= 1'b0;
            bus.wrong_dir <= 1'b0;
        end else begin
            state         <= next_state;
            bus.in_grant  <= (next_state == S_GRANT_IN);
            bus.out_grant <= (next_state == S_GRANT_OUT);
            bus.busy      <= (next_state != S_IDLE);
            bus.timeout   <= expire;
            bus.wrong_dir <= opposite;
            if ((state == S_GRANT_IN) && (next_state == S_GUARD)) begin
                last_served <= DIR_IN;
            end else if ((state == S_GRANT_OUT) && (next_state == S_GUARD)) begin
                last_served <= DIR_OUT;
            end
        end
    end

`ifdef LANE_STATS_EN
    // Completed passages per direction, saturating; timeouts are not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.in_served  <= '0;
            bus.out_served <= '0;
        end else begin
            if ((state == S_GRANT_IN) && bus.enter && (bus.in_served != 8'hFF)) begin
                bus.in_served <= bus.in_served + 8'd1;
            end
            if ((state == S_GRANT_OUT) && bus.exit && (bus.out_served != 8'hFF)) begin
                bus.out_served <= bus.out_served + 8'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_lane_arbiter.sv
// Scoreboard bench for lane_arbiter (TIMEOUT=8, GUARD=2).
module tb_lane_arbiter;

    localparam int EV_IN  = 0;
    localparam int EV_OUT = 1;
    localparam int EV_TO  = 2;
    localparam int EV_WD  = 3;

    typedef struct {
        int kind;
        int len;
    } ev_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    ev_t  exp_q[$];

    lane_arbiter_if bus();

    lane_arbiter #(.TIMEOUT(8), .GUARD(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_ev(input int kind, input int len);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got kind %0d len %0d, expected nothing", kind, len);
        end else begin
            e = exp_q.pop_front();
            if ((e.kind != kind) || (e.len != len)) begin
                errors++;
                $display("FAIL event: got kind %0d len %0d, expected kind %0d len %0d",
                         kind, len, e.kind, e.len);
            end
        end
    endtask

    // Monitor: watches grant windows and status pulses, checks them in order.
    logic prev_in, prev_out;
    int   len_in, len_out;
    always @(negedge clk) begin
        if (!reset) begin
            prev_in  = 1'b0;
            prev_out = 1'b0;
            len_in   = 0;
            len_out  = 0;
        end else begin
            checks++;
            if (bus.in_grant && bus.out_grant) begin
                errors++;
                $display("FAIL mutex: in_grant=1 out_grant=1, expected at most one");
            end
            if (prev_in && !bus.in_grant)   compare_ev(EV_IN, len_in);
            if (prev_out && !bus.out_grant) compare_ev(EV_OUT, len_out);
            if (bus.timeout)   compare_ev(EV_TO, 0);
            if (bus.wrong_dir) compare_ev(EV_WD, 0);
            len_in   = bus.in_grant  ? len_in + 1  : 0;
            len_out  = bus.out_grant ? len_out + 1 : 0;
            prev_in  = bus.in_grant;
            prev_out = bus.out_grant;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for a grant; check its direction and the dark cycles before it.
    task automatic get_grant(input int dir, input int exp_zeros, input string name);
        int zeros;
        zeros = 0;
        while (!(bus.in_grant || bus.out_grant) && zeros < 30) begin
            tick(1);
            zeros++;
        end
        chk({name, " dir"}, bus.out_grant ? 1 : (bus.in_grant ? 0 : -1), dir);
        if (exp_zeros >= 0) chk({name, " gap"}, zeros, exp_zeros);
    endtask

    // Hold the current grant for 'hold' visible cycles, then pulse the passage.
    task automatic serve(input int dir, input int hold, input bit drop_req);
        ev_t e;
        repeat (hold - 1) tick(1);
        if (dir == EV_IN) bus.enter = 1'b1;
        else              bus.exit  = 1'b1;
        if (drop_req) begin
            bus.in_req  = 1'b0;
            bus.out_req = 1'b0;
        end
        e.kind = dir;
        e.len  = hold;
        exp_q.push_back(e);
        tick(1);
        bus.enter = 1'b0;
        bus.exit  = 1'b0;
    endtask

    // Let an entry grant expire; optionally wiggle inputs mid-grant.
    task automatic expire_in(input bit poke, input string name);
        int  len;
        ev_t e;
        e.kind = EV_IN; e.len = 8; exp_q.push_back(e);
        e.kind = EV_TO; e.len = 0; exp_q.push_back(e);
        len = 0;
        while (bus.in_grant && len < 20) begin
            len++;
            if (poke && len == 2) begin
                bus.in_req = 1'b0;
                bus.full   = 1'b1;
            end
            if (poke && len == 4) begin
                bus.in_req  = 1'b1;
                bus.full    = 1'b0;
                bus.out_req = 1'b1;
            end
            tick(1);
        end
        chk({name, " grant length"}, len, 8);
        chk({name, " timeout pulse"}, int'(bus.timeout), 1);
    endtask

    initial begin
        int seen;
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        bus.in_req  = 1'b0;
        bus.out_req = 1'b0;
        bus.enter   = 1'b0;
        bus.exit    = 1'b0;
        bus.full    = 1'b0;
        bus.clear   = 1'b0;

        #2;
        chk("reset outputs", int'({bus.in_grant, bus.out_grant, bus.busy, bus.timeout, bus.wrong_dir}), 0);
`ifdef LANE_STATS_EN
        chk("reset in_served", int'(bus.in_served), 0);
`endif

        // Single entry: grant one cycle after sampling, release, guard, idle.
        bus.in_req = 1'b1;
        tick(2);
        reset = 1'b1;
        chk("pre-grant in_grant", int'(bus.in_grant), 0);
        tick(1);
        chk("first grant in_grant", int'(bus.in_grant), 1);
        chk("first grant busy", int'(bus.busy), 1);
        serve(EV_IN, 3, 1'b1);
        chk("release in_grant", int'(bus.in_grant), 0);
        chk("guard1 busy", int'(bus.busy), 1);
        tick(1);
        chk("guard2 busy", int'(bus.busy), 1);
        tick(1);
        chk("idle busy", int'(bus.busy), 0);

        // Both requesting: round robin starts with exit since entry was served last.
        bus.in_req  = 1'b1;
        bus.out_req = 1'b1;
        get_grant(EV_OUT, 1, "rr1");
        serve(EV_OUT, 2, 1'b0);
        get_grant(EV_IN, 2, "rr2");
        serve(EV_IN, 4, 1'b0);
        get_grant(EV_OUT, 2, "rr3");
        serve(EV_OUT, 1, 1'b0);
        get_grant(EV_IN, 2, "rr4");
        serve(EV_IN, 3, 1'b1);
        tick(2);
        chk("rr idle busy", int'(bus.busy), 0);

        // Full lot blocks entry; empty lot blocks exit.
        bus.in_req = 1'b1;
        bus.full   = 1'b1;
        seen = 0;
        repeat (20) begin
            tick(1);
            if (bus.in_grant || bus.out_grant || bus.busy) seen = 1;
        end
        chk("full blocks entry", seen, 0);
        bus.in_req  = 1'b0;
        bus.full    = 1'b0;
        bus.out_req = 1'b1;
        bus.clear   = 1'b1;
        seen = 0;
        repeat (20) begin
            tick(1);
            if (bus.in_grant || bus.out_grant || bus.busy) seen = 1;
        end
        chk("clear blocks exit", seen, 0);
        bus.out_req = 1'b0;
        bus.clear   = 1'b0;

        // Timeout with mid-grant request/full changes; exit is served next.
        bus.in_req = 1'b1;
        get_grant(EV_IN, 1, "to grant");
        expire_in(1'b1, "timeout");
        get_grant(EV_OUT, 2, "after timeout");
        serve(EV_OUT, 2, 1'b1);
        bus.in_req = 1'b1;
        get_grant(EV_IN, 2, "tie grant");
        serve(EV_IN, 8, 1'b0);
        chk("pulse beats expiry", int'(bus.timeout), 0);

        // Opposite-direction pulse during an entry grant.
        get_grant(EV_IN, 2, "wd grant");
        tick(1);
        bus.exit = 1'b1;
        exp_q.push_back('{EV_WD, 0});
        tick(1);
        bus.exit = 1'b0;
        chk("wrong_dir pulse", int'(bus.wrong_dir), 1);
        chk("wrong_dir keeps grant", int'(bus.in_grant), 1);
        tick(1);
        chk("wrong_dir single", int'(bus.wrong_dir), 0);
        bus.enter = 1'b1;
        exp_q.push_back('{EV_IN, 4});
        tick(1);
        bus.enter = 1'b0;
        chk("wd release", int'(bus.in_grant), 0);

        // Reset mid-grant drops the light at once and restores the tie-break.
        get_grant(EV_IN, 2, "rst grant");
        tick(1);
        reset = 1'b0;
        #1;
        chk("async reset in_grant", int'(bus.in_grant), 0);
        chk("async reset busy", int'(bus.busy), 0);
        bus.out_req = 1'b1;
        tick(2);
        reset = 1'b1;
        get_grant(EV_IN, 1, "post-reset tie");
        serve(EV_IN, 1, 1'b0);
        get_grant(EV_OUT, 2, "post-reset rr");
        serve(EV_OUT, 1, 1'b1);
        tick(2);
        chk("post-reset idle", int'(bus.busy), 0);

`ifdef LANE_STATS_EN
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        chk("stats reset", int'(bus.in_served), 0);
        bus.in_req = 1'b1;
        repeat (3) begin
            get_grant(EV_IN, -1, "stats in");
            serve(EV_IN, 1, 1'b0);
        end
        get_grant(EV_IN, -1, "stats to");
        expire_in(1'b0, "stats timeout");
        bus.in_req  = 1'b0;
        bus.out_req = 1'b1;
        get_grant(EV_OUT, -1, "stats out1");
        serve(EV_OUT, 1, 1'b0);
        get_grant(EV_OUT, -1, "stats out2");
        serve(EV_OUT, 1, 1'b1);
        tick(3);
        chk("in_served", int'(bus.in_served), 3);
        chk("out_served", int'(bus.out_served), 2);
        bus.in_req = 1'b1;
        for (int i = 0; i < 297; i++) begin
            get_grant(EV_IN, -1, "bulk");
            serve(EV_IN, 1, i == 296);
        end
        tick(3);
        chk("in_served saturates", int'(bus.in_served), 255);
        chk("out_served unchanged", int'(bus.out_served), 2);
`endif

        tick(2);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
